// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit
//   MEM-stage consumer of the EX/MEM register. Runs the data-memory request/ready
//   handshake for loads and stores, stalls the front of the pipeline while an access
//   is outstanding, and owns the MEM/WB pipeline register.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   MEM_*                    EX/MEM register outputs (controls, address, store data, rd, PC+4)
//   mem_req/we/addr/wdata    registered data-memory request
//   mem_rdata, mem_ready     data-memory response (ready only looked at in REQ)
//   stall                    combinational; holds EX/MEM and earlier stages
//   WB_*                     MEM/WB register outputs
//   mem_error                sticky access-timeout flag
//
// Build option
//   MEM_TIMEOUT_EN  when defined, a REQ lasting TIMEOUT_CYCLES without mem_ready is
//                   aborted with all-ones read data and mem_error set. When undefined,
//                   REQ waits for mem_ready indefinitely and mem_error is tied low.
module mem_stage_access_unit #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MEM_MemRead,
  input  logic                      MEM_MemWrite,
  input  logic                      MEM_RegWrite,
  input  logic                      MEM_MemtoReg,
  input  logic [DATA_WIDTH-1:0]     MEM_ALUResult,
  input  logic [DATA_WIDTH-1:0]     MEM_BusB_forwarded,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WriteRegister,
  input  logic [DATA_WIDTH-1:0]     MEM_PC4,
  input  logic                      MEM_JLControl,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready,
  output logic                      stall,
  output logic                      WB_RegWrite,
  output logic                      WB_MemtoReg,
  output logic                      WB_JLControl,
  output logic [DATA_WIDTH-1:0]     WB_ReadData,
  output logic [DATA_WIDTH-1:0]     WB_ALUResult,
  output logic [DATA_WIDTH-1:0]     WB_PC4,
  output logic [REG_ADDR_WIDTH-1:0] WB_WriteRegister,
  output logic                      mem_error
);

  // Timeout limit must be non-zero and representable in the counter.
  if ((TIMEOUT_CYCLES == 32'd0) ||
      (64'(TIMEOUT_CYCLES) >= (64'(1) << TIMEOUT_WIDTH))) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1 .. 2**TIMEOUT_WIDTH-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      wb_regwrite_q, wb_regwrite_d;
  logic                      wb_memtoreg_q, wb_memtoreg_d;
  logic                      wb_jl_q, wb_jl_d;
  logic [DATA_WIDTH-1:0]     wb_rdata_q, wb_rdata_d;
  logic [DATA_WIDTH-1:0]     wb_alu_q, wb_alu_d;
  logic [DATA_WIDTH-1:0]     wb_pc4_q, wb_pc4_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;

  logic access_c;
  logic load_c;

  // A simultaneous read+write is treated as a write.
  assign access_c = MEM_MemRead | MEM_MemWrite;
  assign load_c   = MEM_MemRead & ~MEM_MemWrite;
  assign stall    = access_c & (state_q != ST_DONE);

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                     err_q, err_d;
`endif

  // Next-state, memory request and MEM/WB register update.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_jl_d       = wb_jl_q;
    wb_rdata_d    = wb_rdata_q;
    wb_alu_d      = wb_alu_q;
    wb_pc4_d      = wb_pc4_q;
    wb_rd_d       = wb_rd_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;
          addr_d  = MEM_ALUResult;
          wdata_d = MEM_BusB_forwarded;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          rdata_d = mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        // Abort on the edge that ends the TIMEOUT_CYCLES-th unanswered REQ cycle.
        else if (tmo_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 32'd1)) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          rdata_d = '1;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Stalled cycles leave a bubble in WB; data fields keep their last values.
    if (!stall) begin
      wb_regwrite_d = MEM_RegWrite;
      wb_memtoreg_d = MEM_MemtoReg;
      wb_jl_d       = MEM_JLControl;
      wb_rdata_d    = load_c ? rdata_q : '0;
      wb_alu_d      = MEM_ALUResult;
      wb_pc4_d      = MEM_PC4;
      wb_rd_d       = MEM_WriteRegister;
    end else begin
      wb_regwrite_d = 1'b0;
      wb_memtoreg_d = 1'b0;
    end
  end

  // State and output registers; reset also drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_jl_q       <= 1'b0;
      wb_rdata_q    <= '0;
      wb_alu_q      <= '0;
      wb_pc4_q      <= '0;
      wb_rd_q       <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_jl_q       <= wb_jl_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_alu_q      <= wb_alu_d;
      wb_pc4_q      <= wb_pc4_d;
      wb_rd_q       <= wb_rd_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign WB_RegWrite      = wb_regwrite_q;
  assign WB_MemtoReg      = wb_memtoreg_q;
  assign WB_JLControl     = wb_jl_q;
  assign WB_ReadData      = wb_rdata_q;
  assign WB_ALUResult     = wb_alu_q;
  assign WB_PC4           = wb_pc4_q;
  assign WB_WriteRegister = wb_rd_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_error        = err_q;
`else
  assign mem_error        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit; built with or without MEM_TIMEOUT_EN.
module tb_mem_stage_access_unit;

  localparam int unsigned DW  = 16;
  localparam int unsigned RAW = 2;

  logic           clk;
  logic           reset;
  logic           MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg, MEM_JLControl;
  logic [DW-1:0]  MEM_ALUResult, MEM_BusB_forwarded, MEM_PC4;
  logic [RAW-1:0] MEM_WriteRegister;
  logic           mem_req, mem_we, mem_ready, stall, mem_error;
  logic [DW-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic           WB_RegWrite, WB_MemtoReg, WB_JLControl;
  logic [DW-1:0]  WB_ReadData, WB_ALUResult, WB_PC4;
  logic [RAW-1:0] WB_WriteRegister;

  int checks = 0;
  int errors = 0;

  mem_stage_access_unit #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(RAW),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .MEM_MemRead       (MEM_MemRead),
    .MEM_MemWrite      (MEM_MemWrite),
    .MEM_RegWrite      (MEM_RegWrite),
    .MEM_MemtoReg      (MEM_MemtoReg),
    .MEM_ALUResult     (MEM_ALUResult),
    .MEM_BusB_forwarded(MEM_BusB_forwarded),
    .MEM_WriteRegister (MEM_WriteRegister),
    .MEM_PC4           (MEM_PC4),
    .MEM_JLControl     (MEM_JLControl),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ready         (mem_ready),
    .stall             (stall),
    .WB_RegWrite       (WB_RegWrite),
    .WB_MemtoReg       (WB_MemtoReg),
    .WB_JLControl      (WB_JLControl),
    .WB_ReadData       (WB_ReadData),
    .WB_ALUResult      (WB_ALUResult),
    .WB_PC4            (WB_PC4),
    .WB_WriteRegister  (WB_WriteRegister),
    .mem_error         (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [DW-1:0] alu, input logic [DW-1:0] busb,
                       input logic [RAW-1:0] rd_addr, input logic [DW-1:0] pc4);
    MEM_MemRead        = rd;
    MEM_MemWrite       = wr;
    MEM_RegWrite       = rw;
    MEM_MemtoReg       = m2r;
    MEM_ALUResult      = alu;
    MEM_BusB_forwarded = busb;
    MEM_WriteRegister  = rd_addr;
    MEM_PC4            = pc4;
    MEM_JLControl      = 1'b0;
  endtask

  task automatic drive_nop;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 16'h0000);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive_nop();

    // Reset held two cycles
    tick();
    tick();
    check_eq("rst_mem_req",  32'(mem_req), 32'h0);
    check_eq("rst_mem_we",   32'(mem_we), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_wdata",    32'(mem_wdata), 32'h0);
    check_eq("rst_wb_rw",    32'(WB_RegWrite), 32'h0);
    check_eq("rst_wb_m2r",   32'(WB_MemtoReg), 32'h0);
    check_eq("rst_wb_rdata", 32'(WB_ReadData), 32'h0);
    check_eq("rst_wb_alu",   32'(WB_ALUResult), 32'h0);
    check_eq("rst_wb_pc4",   32'(WB_PC4), 32'h0);
    check_eq("rst_wb_rd",    32'(WB_WriteRegister), 32'h0);
    check_eq("rst_error",    32'(mem_error), 32'h0);
    check_eq("rst_stall",    32'(stall), 32'h0);

    // ALU op passes with 1-cycle latency
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'd2, 16'h0008);
    #1 check_eq("alu_stall", 32'(stall), 32'h0);
    tick();
    check_eq("alu_wb_alu",  32'(WB_ALUResult), 32'h1234);
    check_eq("alu_wb_rw",   32'(WB_RegWrite), 32'h1);
    check_eq("alu_wb_rd",   32'(WB_WriteRegister), 32'h2);
    check_eq("alu_wb_pc4",  32'(WB_PC4), 32'h0008);
    check_eq("alu_wb_rdat", 32'(WB_ReadData), 32'h0);
    check_eq("alu_mem_req", 32'(mem_req), 32'h0);

    // Load, ready on first REQ cycle
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 2'd1, 16'h000C);
    #1 check_eq("ld_stall_idle", 32'(stall), 32'h1);
    tick();
    check_eq("ld_req",      32'(mem_req), 32'h1);
    check_eq("ld_we",       32'(mem_we), 32'h0);
    check_eq("ld_addr",     32'(mem_addr), 32'h0040);
    check_eq("ld_bubble",   32'(WB_RegWrite), 32'h0);
    check_eq("ld_bub_m2r",  32'(WB_MemtoReg), 32'h0);
    check_eq("ld_hold_alu", 32'(WB_ALUResult), 32'h1234);
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    #1 check_eq("ld_stall_req", 32'(stall), 32'h1);
    tick();
    check_eq("ld_req_drop", 32'(mem_req), 32'h0);
    check_eq("ld_bubble2",  32'(WB_RegWrite), 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    #1 check_eq("ld_stall_done", 32'(stall), 32'h0);
    tick();
    check_eq("ld_wb_rdata", 32'(WB_ReadData), 32'hBEEF);
    check_eq("ld_wb_rw",    32'(WB_RegWrite), 32'h1);
    check_eq("ld_wb_m2r",   32'(WB_MemtoReg), 32'h1);
    check_eq("ld_wb_alu",   32'(WB_ALUResult), 32'h0040);
    check_eq("ld_wb_rd",    32'(WB_WriteRegister), 32'h1);
    check_eq("ld_wb_pc4",   32'(WB_PC4), 32'h000C);

    // Store, ready after three wait cycles; read data on the bus must not reach WB
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 2'd3, 16'h0010);
    #1 check_eq("st_stall_idle", 32'(stall), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("st_req",   32'(mem_req), 32'h1);
      check_eq("st_we",    32'(mem_we), 32'h1);
      check_eq("st_addr",  32'(mem_addr), 32'h0010);
      check_eq("st_wdata", 32'(mem_wdata), 32'hA5A5);
      mem_ready = (i == 3);
      mem_rdata = 16'h2222;
      #1 check_eq("st_stall_req", 32'(stall), 32'h1);
    end
    tick();
    check_eq("st_req_drop", 32'(mem_req), 32'h0);
    mem_ready = 1'b0;
    #1 check_eq("st_stall_done", 32'(stall), 32'h0);
    tick();
    check_eq("st_wb_rdata", 32'(WB_ReadData), 32'h0);
    check_eq("st_wb_rw",    32'(WB_RegWrite), 32'h0);
    check_eq("st_wb_alu",   32'(WB_ALUResult), 32'h0010);

    // Reset during REQ abandons the access
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0080, 16'h0000, 2'd1, 16'h0014);
    tick();
    check_eq("rr_req", 32'(mem_req), 32'h1);
    reset = 1'b1;
    tick();
    check_eq("rr_req_drop", 32'(mem_req), 32'h0);
    check_eq("rr_wb_rw",    32'(WB_RegWrite), 32'h0);
    check_eq("rr_addr",     32'(mem_addr), 32'h0);
    check_eq("rr_wb_rdata", 32'(WB_ReadData), 32'h0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0022, 16'h0000, 2'd2, 16'h0018);
    tick();
    check_eq("rr_new_req",  32'(mem_req), 32'h1);
    check_eq("rr_new_addr", 32'(mem_addr), 32'h0022);
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("rr_new_rdata", 32'(WB_ReadData), 32'h5A5A);

`ifdef MEM_TIMEOUT_EN
    // Timeout: four unanswered REQ cycles abort the access
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 2'd3, 16'h001C);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("to_req",   32'(mem_req), 32'h1);
      check_eq("to_err0",  32'(mem_error), 32'h0);
      check_eq("to_stall", 32'(stall), 32'h1);
    end
    tick();
    check_eq("to_req_drop", 32'(mem_req), 32'h0);
    check_eq("to_err",      32'(mem_error), 32'h1);
    check_eq("to_release",  32'(stall), 32'h0);
    tick();
    check_eq("to_wb_rdata", 32'(WB_ReadData), 32'hFFFF);
    check_eq("to_wb_rw",    32'(WB_RegWrite), 32'h1);
    drive_nop();
    tick();
    tick();
    check_eq("to_err_sticky", 32'(mem_error), 32'h1);
`else
    // Without the timeout, REQ waits for ready however long it takes
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 2'd3, 16'h001C);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("wait_req", 32'(mem_req), 32'h1);
    end
    check_eq("wait_stall", 32'(stall), 32'h1);
    check_eq("wait_err",   32'(mem_error), 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 16'h0F0F;
    tick();
    mem_ready = 1'b0;
    check_eq("wait_done_stall", 32'(stall), 32'h0);
    tick();
    check_eq("wait_wb_rdata", 32'(WB_ReadData), 32'h0F0F);
    check_eq("wait_err_end",  32'(mem_error), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
